// File: rtl/cordic_rot_iter_pkg.sv
// cordic_pkg: shared widths, atan table, state encoding and saturation for the CORDIC engine
package cordic_pkg;
  localparam int DATA_W = 12;
  localparam int INT_W = 14;
  localparam int ANG_W = 12;
  localparam int NUM_ITER = 11;
  localparam int ANG_LIM = 1608;
  localparam int K_GAIN = 1244;
  localparam int SAT_MAX = 2 ** (DATA_W - 1) - 1;
  localparam int SAT_MIN = -(2 ** (DATA_W - 1));
  localparam logic signed [ANG_W:0] ATAN_LUT [0:10] = '{
    13'sd804, 13'sd475, 13'sd251, 13'sd127, 13'sd64, 13'sd32,
    13'sd16, 13'sd8, 13'sd4, 13'sd2, 13'sd1
  };
  typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;
  function automatic logic signed [DATA_W-1:0] saturate(input logic signed [INT_W-1:0] v);
    return int'(v) > SAT_MAX ? DATA_W'(SAT_MAX) : int'(v) < SAT_MIN ? DATA_W'(SAT_MIN) : DATA_W'(v);
  endfunction
endpackage

// File: rtl/cordic_rot_iter_if.sv
// cordic_rot_iter_if: block handshake plus operand/result bus of the CORDIC rotation engine
interface cordic_rot_iter_if import cordic_pkg::*; #(
  parameter int DW = DATA_W,
  parameter int AW = ANG_W
);
  logic ap_start;
  logic ap_ready;
  logic ap_idle;
  logic ap_done;
  logic signed [AW-1:0] theta;
  logic signed [DW-1:0] x0;
  logic signed [DW-1:0] y0;
  logic signed [DW-1:0] x_out;
  logic signed [DW-1:0] y_out;
  modport master (
    output ap_start, theta, x0, y0,
    input ap_ready, ap_idle, ap_done, x_out, y_out
  );
  modport slave (
    input ap_start, theta, x0, y0,
    output ap_ready, ap_idle, ap_done, x_out, y_out
  );
endinterface

// File: rtl/cordic_micro_rot.sv
// cordic_micro_rot: one combinational rotation-mode CORDIC step driven by the sign of z
module cordic_micro_rot import cordic_pkg::*; #(
  parameter int W = INT_W,
  parameter int ZW = ANG_W + 1
) (
  input  logic signed [W-1:0]  i_x,
  input  logic signed [W-1:0]  i_y,
  input  logic signed [ZW-1:0] i_z,
  input  logic signed [ZW-1:0] i_atan,
  input  logic [3:0]           i_sh,
  output logic signed [W-1:0]  o_x,
  output logic signed [W-1:0]  o_y,
  output logic signed [ZW-1:0] o_z
);
  logic signed [W-1:0] w_xs;
  logic signed [W-1:0] w_ys;
  logic w_neg;
  assign w_xs = i_x >>> i_sh;
  assign w_ys = i_y >>> i_sh;
  assign w_neg = i_z[ZW-1];
  always_comb begin
    o_x = w_neg ? i_x + w_ys : i_x - w_ys;
    o_y = w_neg ? i_y - w_xs : i_y + w_xs;
    o_z = w_neg ? i_z + i_atan : i_z - i_atan;
  end
endmodule

// File: rtl/cordic_rot_iter.sv
// cordic_rot_iter: iterative rotation-mode CORDIC, one micro-rotation per clock, unscaled output
module cordic_rot_iter #(
  parameter int NUM_ITER = cordic_pkg::NUM_ITER,
  parameter int DATA_W = cordic_pkg::DATA_W,
  parameter int INT_W = cordic_pkg::INT_W,
  parameter int ANG_W = cordic_pkg::ANG_W
) (
  input logic ap_clk,
  input logic ap_rst,
  cordic_rot_iter_if.slave io_bus
);
  import cordic_pkg::*;
  localparam int Z_W = ANG_W + 1;
  state_t r_state;
  logic [3:0] r_i;
  logic signed [INT_W-1:0] r_x;
  logic signed [INT_W-1:0] r_y;
  logic signed [Z_W-1:0] r_z;
  logic signed [DATA_W-1:0] r_x_out;
  logic signed [DATA_W-1:0] r_y_out;
  logic r_done;
  logic signed [INT_W-1:0] w_x;
  logic signed [INT_W-1:0] w_y;
  logic signed [Z_W-1:0] w_z;
  logic signed [Z_W-1:0] w_z_load;
  int w_theta;
  assign w_theta = int'(io_bus.theta);
  assign w_z_load = w_theta > ANG_LIM ? Z_W'(ANG_LIM) : w_theta < -ANG_LIM ? Z_W'(-ANG_LIM) : Z_W'(w_theta);
  cordic_micro_rot #(.W(INT_W), .ZW(Z_W)) u_rot (
    .i_x(r_x),
    .i_y(r_y),
    .i_z(r_z),
    .i_atan(ATAN_LUT[r_i]),
    .i_sh(r_i),
    .o_x(w_x),
    .o_y(w_y),
    .o_z(w_z)
  );
  assign io_bus.ap_ready = (r_state == S_IDLE) & io_bus.ap_start;
  assign io_bus.ap_idle = (r_state == S_IDLE) & ~io_bus.ap_start;
  assign io_bus.ap_done = r_done;
  assign io_bus.x_out = r_x_out;
  assign io_bus.y_out = r_y_out;
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_state <= S_IDLE;
      r_i <= '0;
      r_x <= '0;
      r_y <= '0;
      r_z <= '0;
      r_x_out <= '0;
      r_y_out <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (io_bus.ap_start) begin
          r_x <= INT_W'(io_bus.x0);
          r_y <= INT_W'(io_bus.y0);
          r_z <= w_z_load;
          r_i <= '0;
          r_state <= S_ITER;
        end
        S_ITER: begin
          r_x <= w_x;
          r_y <= w_y;
          r_z <= w_z;
          r_i <= r_i + 4'd1;
          if (r_i == 4'(NUM_ITER - 1)) begin
            r_x_out <= saturate(w_x);
            r_y_out <= saturate(w_y);
            r_done <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cordic_rot_iter.sv
// tb_cordic_rot_iter: directed-vector bench for the iterative CORDIC rotation engine
module tb_cordic_rot_iter;
  logic ap_clk = 1'b0;
  logic ap_rst;
  int checks = 0;
  int errors = 0;

  cordic_rot_iter_if bus();

  cordic_rot_iter dut (
    .ap_clk(ap_clk),
    .ap_rst(ap_rst),
    .io_bus(bus)
  );

  always #5 ap_clk = ~ap_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic run_op(input int th, input int xv, input int yv,
                        output int lat, output logic rdy, output int xo, output int yo);
    @(negedge ap_clk);
    bus.theta = 12'(th);
    bus.x0 = 12'(xv);
    bus.y0 = 12'(yv);
    bus.ap_start = 1'b1;
    #1 rdy = bus.ap_ready;
    @(negedge ap_clk);
    bus.ap_start = 1'b0;
    bus.theta = -12'sd700;
    bus.x0 = -12'sd1500;
    bus.y0 = 12'sd900;
    lat = -1;
    xo = 0;
    yo = 0;
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      if (bus.ap_done === 1'b1) begin
        lat = k;
        xo = int'(bus.x_out);
        yo = int'(bus.y_out);
      end else @(negedge ap_clk);
    end
  endtask

  task automatic test_reset();
    ap_rst = 1'b1;
    bus.ap_start = 1'b0;
    bus.theta = '0;
    bus.x0 = '0;
    bus.y0 = '0;
    repeat (3) @(negedge ap_clk);
    checks++; if (bus.ap_idle !== 1'b1) begin errors++; $display("FAIL reset ap_idle got %b want 1", bus.ap_idle); end
    checks++; if (bus.ap_ready !== 1'b0) begin errors++; $display("FAIL reset ap_ready got %b want 0", bus.ap_ready); end
    checks++; if (bus.ap_done !== 1'b0) begin errors++; $display("FAIL reset ap_done got %b want 0", bus.ap_done); end
    checks++; if (bus.x_out !== 12'sd0) begin errors++; $display("FAIL reset x_out got %0d want 0", bus.x_out); end
    checks++; if (bus.y_out !== 12'sd0) begin errors++; $display("FAIL reset y_out got %0d want 0", bus.y_out); end
    ap_rst = 1'b0;
  endtask

  task automatic test_rotate();
    int th[5] = '{0, 804, -1608, 2047, 804};
    int xi[5] = '{1024, 1024, 1024, 1024, 1024};
    int yi[5] = '{0, 0, 0, 0, 1024};
    int ex[5] = '{1686, 1192, 0, 0, 0};
    int ey[5] = '{0, 1192, -1686, 1686, 2047};
    int ty[5] = '{3, 3, 3, 3, 0};
    int lat, xo, yo;
    logic rdy;
    for (int n = 0; n < 5; n++) begin
      run_op(th[n], xi[n], yi[n], lat, rdy, xo, yo);
      checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL rot%0d ap_ready got %b want 1", n, rdy); end
      checks++; if (lat !== 12) begin errors++; $display("FAIL rot%0d latency got %0d want 12", n, lat); end
      checks++; if (xo - ex[n] > 3 || ex[n] - xo > 3) begin errors++; $display("FAIL rot%0d x_out got %0d want %0d+-3", n, xo, ex[n]); end
      checks++; if (yo - ey[n] > ty[n] || ey[n] - yo > ty[n]) begin errors++; $display("FAIL rot%0d y_out got %0d want %0d+-%0d", n, yo, ey[n], ty[n]); end
      @(negedge ap_clk);
      checks++; if (bus.ap_done !== 1'b0) begin errors++; $display("FAIL rot%0d done_pulse got %b want 0", n, bus.ap_done); end
      checks++; if (int'(bus.x_out) - ex[n] > 3 || ex[n] - int'(bus.x_out) > 3) begin errors++; $display("FAIL rot%0d x_hold got %0d want %0d+-3", n, bus.x_out, ex[n]); end
    end
  endtask

  task automatic test_back_to_back();
    int th[3] = '{0, -1608, 804};
    int ex[3] = '{1686, 0, 1192};
    int ey[3] = '{0, -1686, 1192};
    int ea[3] = '{0, 13, 26};
    int ed[3] = '{12, 25, 38};
    int acc[3] = '{-1, -1, -1};
    int dn[3] = '{-1, -1, -1};
    int xo[3] = '{0, 0, 0};
    int yo[3] = '{0, 0, 0};
    int na = 0;
    int nd = 0;
    @(negedge ap_clk);
    bus.theta = 12'(th[0]);
    bus.x0 = 12'sd1024;
    bus.y0 = 12'sd0;
    bus.ap_start = 1'b1;
    for (int c = 0; c <= 38; c++) begin
      if (na > 0 && na < 3 && c == acc[na-1] + 1) begin
        bus.theta = -12'sd1000;
        bus.x0 = -12'sd2000;
        bus.y0 = 12'sd500;
      end
      if (na > 0 && na < 3 && c == acc[na-1] + 6) begin
        bus.theta = 12'(th[na]);
        bus.x0 = 12'sd1024;
        bus.y0 = 12'sd0;
      end
      #1;
      if (bus.ap_ready === 1'b1) begin
        if (na < 3) acc[na] = c;
        na++;
      end
      if (bus.ap_done === 1'b1) begin
        if (nd < 3) begin
          dn[nd] = c;
          xo[nd] = int'(bus.x_out);
          yo[nd] = int'(bus.y_out);
        end
        nd++;
      end
      if (c == 20) begin
        checks++; if (int'(bus.x_out) - 1686 > 3 || 1686 - int'(bus.x_out) > 3) begin errors++; $display("FAIL b2b x_hold_mid got %0d want 1686+-3", bus.x_out); end
      end
      @(negedge ap_clk);
    end
    bus.ap_start = 1'b0;
    checks++; if (na !== 3) begin errors++; $display("FAIL b2b ready_count got %0d want 3", na); end
    checks++; if (nd !== 3) begin errors++; $display("FAIL b2b done_count got %0d want 3", nd); end
    for (int n = 0; n < 3; n++) begin
      checks++; if (acc[n] !== ea[n]) begin errors++; $display("FAIL b2b accept%0d cycle got %0d want %0d", n, acc[n], ea[n]); end
      checks++; if (dn[n] !== ed[n]) begin errors++; $display("FAIL b2b done%0d cycle got %0d want %0d", n, dn[n], ed[n]); end
      checks++; if (xo[n] - ex[n] > 3 || ex[n] - xo[n] > 3) begin errors++; $display("FAIL b2b op%0d x_out got %0d want %0d+-3", n, xo[n], ex[n]); end
      checks++; if (yo[n] - ey[n] > 3 || ey[n] - yo[n] > 3) begin errors++; $display("FAIL b2b op%0d y_out got %0d want %0d+-3", n, yo[n], ey[n]); end
    end
  endtask

  task automatic test_reset_abort();
    int lat, xo, yo;
    logic rdy;
    bit seen = 1'b0;
    @(negedge ap_clk);
    bus.theta = 12'sd804;
    bus.x0 = 12'sd1024;
    bus.y0 = 12'sd0;
    bus.ap_start = 1'b1;
    @(negedge ap_clk);
    bus.ap_start = 1'b0;
    repeat (5) @(negedge ap_clk);
    ap_rst = 1'b1;
    @(negedge ap_clk);
    ap_rst = 1'b0;
    checks++; if (bus.ap_idle !== 1'b1) begin errors++; $display("FAIL abort ap_idle got %b want 1", bus.ap_idle); end
    checks++; if (bus.x_out !== 12'sd0) begin errors++; $display("FAIL abort x_out got %0d want 0", bus.x_out); end
    checks++; if (bus.y_out !== 12'sd0) begin errors++; $display("FAIL abort y_out got %0d want 0", bus.y_out); end
    ap_rst = 1'b1;
    bus.ap_start = 1'b1;
    @(negedge ap_clk);
    ap_rst = 1'b0;
    bus.ap_start = 1'b0;
    #1;
    checks++; if (bus.ap_idle !== 1'b1) begin errors++; $display("FAIL rst_priority ap_idle got %b want 1", bus.ap_idle); end
    for (int k = 0; k < 16; k++) begin
      if (bus.ap_done === 1'b1) seen = 1'b1;
      @(negedge ap_clk);
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort no_done got %b want 0", seen); end
    run_op(-1608, 1024, 0, lat, rdy, xo, yo);
    checks++; if (lat !== 12) begin errors++; $display("FAIL post_abort latency got %0d want 12", lat); end
    checks++; if (xo > 3 || xo < -3) begin errors++; $display("FAIL post_abort x_out got %0d want 0+-3", xo); end
    checks++; if (yo + 1686 > 3 || -1686 - yo > 3) begin errors++; $display("FAIL post_abort y_out got %0d want -1686+-3", yo); end
  endtask

  initial begin
    test_reset();
    test_rotate();
    test_back_to_back();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
